// File: rtl/hazard_stall_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use and branch
// stalls, control flushes, and a wait-state FSM for the data memory.
// Ports: CLOCK/RESET; ID/EX/MEM/WB register tags and controls in;
// Forward*, Stall*, Flush*, mem_req, mem_err, stall_cnt out.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       wb_addrE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       wb_addrM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [4:0]       wb_addrW,
  input  logic             RegWriteW,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wcnt;

  logic mem_acc;
  logic mem_stall;
  logic lw_stall;
  logic br_stall;
  logic hz;
  logic e_hit_d;
  logic m_hit_d;

  assign mem_acc = MemReadM || MemWriteM;

  // EX/MEM destination matches either ID source
  assign e_hit_d = (wb_addrE != 5'd0) &&
                   ((wb_addrE == rsD) || (wb_addrE == rtD));
  assign m_hit_d = (wb_addrM != 5'd0) &&
                   ((wb_addrM == rsD) || (wb_addrM == rtD));

  assign lw_stall = MemtoRegE && RegWriteE && e_hit_d;
  assign br_stall = BranchD &&
                    ((RegWriteE && e_hit_d) || (MemtoRegM && m_hit_d));
  assign hz = lw_stall || br_stall;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!RESET) begin
      if (RegWriteM && wb_addrM != 5'd0 && wb_addrM == rsE)
        ForwardAE = 2'b10;
      else if (RegWriteW && wb_addrW != 5'd0 && wb_addrW == rsE)
        ForwardAE = 2'b01;
      if (RegWriteM && wb_addrM != 5'd0 && wb_addrM == rtE)
        ForwardBE = 2'b10;
      else if (RegWriteW && wb_addrW != 5'd0 && wb_addrW == rtE)
        ForwardBE = 2'b01;
      ForwardAD = (rsD != 5'd0) && (rsD == wb_addrM) && RegWriteM;
      ForwardBD = (rtD != 5'd0) && (rtD == wb_addrM) && RegWriteM;
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    mem_req   = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = mem_acc && !mem_ready;
        mem_req   = mem_acc;
      end
      MEM_WAIT: begin
        mem_stall = !mem_ready;
        mem_req   = 1'b1;
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: ;
    endcase
    // aborts an in-flight access without waiting for the edge
    if (RESET) mem_req = 1'b0;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (RESET) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = hz;
      StallD = hz;
      FlushE = hz;
      FlushD = (PCSrcD || JumpD) && !hz;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wcnt      <= 8'd0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (StallF && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (mem_acc && !mem_ready) begin
            state <= MEM_WAIT;
            wcnt  <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= IDLE;
            wcnt  <= 8'd0;
          end else if (wcnt == TMO) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
